data_mem_responder: RTL

//  Responder end of the pipeline's M-stage data-memory interface. It services stores issued
//  by the core (Mem_WrAddr, Mem_WrData, MemWriteM, funct3M) with byte-lane writes, and returns

---
 rtl/data_mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - M-stage data-memory responder: byte-lane RAM, funct3 load extension, MMIO counters/mailbox
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        misalign_err,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [63:0] cycle_q, cycle_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;

  logic          in_ram, in_mmio;
  logic [31:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          size_ok, aligned, lw_ok;
  logic          ram_wr, mmio_sw, new_err, err_clr, tohost_wr;
  logic [3:0]    be;
  logic [31:0]   wdata;

  assign in_ram   = Mem_WrAddr < RAM_BYTES;
  assign mmio_off = Mem_WrAddr - MMIO_BASE;
  assign in_mmio  = (Mem_WrAddr >= MMIO_BASE) && (mmio_off < 32'h20);
  assign ram_idx  = Mem_WrAddr[AW+1:2];
  assign lw_ok    = (funct3M == 3'b010) && (Mem_WrAddr[1:0] == 2'b00);

  // Loads: purely combinational from current address/funct3; same-cycle stores are not visible.
  always_comb begin
    rd_word  = '0;
    ReadData = '0;
    if (in_ram) rd_word = mem_q[ram_idx];
    rd_byte = rd_word[{Mem_WrAddr[1:0], 3'b000} +: 8];
    rd_half = Mem_WrAddr[1] ? rd_word[31:16] : rd_word[15:0];
    if (in_ram) begin
      case (funct3M)
        3'b000:  ReadData = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  ReadData = {24'h0, rd_byte};
        3'b001:  ReadData = Mem_WrAddr[0] ? 32'h0 : {{16{rd_half[15]}}, rd_half};
        3'b101:  ReadData = Mem_WrAddr[0] ? 32'h0 : {16'h0, rd_half};
        3'b010:  ReadData = lw_ok ? rd_word : 32'h0;
        default: ReadData = '0;
      endcase
    end else if (in_mmio && lw_ok) begin
      case (mmio_off[4:2])
        3'd0:    ReadData = cycle_q[31:0];
        3'd1:    ReadData = cycle_q[63:32];
        3'd2:    ReadData = store_cnt_q;
        3'd3:    ReadData = tohost_data_q;
        3'd4:    ReadData = err_addr_q;
        3'd5:    ReadData = {31'h0, err_q};
        default: ReadData = '0;
      endcase
    end
  end

  always_comb begin
    size_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    case (funct3M)
      3'b001:  aligned = ~Mem_WrAddr[0];
      3'b010:  aligned = (Mem_WrAddr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (funct3M)
      3'b000:  begin be = 4'b0001 << Mem_WrAddr[1:0]; wdata = {4{Mem_WrData[7:0]}};  end
      3'b001:  begin be = Mem_WrAddr[1] ? 4'b1100 : 4'b0011; wdata = {2{Mem_WrData[15:0]}}; end
      default: begin be = 4'b1111; wdata = Mem_WrData; end
    endcase
    // Out-of-range stores are dropped before any size/alignment judgement.
    ram_wr    = MemWriteM && in_ram && size_ok && aligned;
    mmio_sw   = MemWriteM && in_mmio && lw_ok;
    new_err   = MemWriteM && ((in_ram && !(size_ok && aligned)) || (in_mmio && !lw_ok));
    err_clr   = mmio_sw && (mmio_off[4:2] == 3'd5) && Mem_WrData[0];
    tohost_wr = mmio_sw && (mmio_off[4:2] == 3'd3);

    cycle_d        = cycle_q + 64'd1;
    store_cnt_d    = (ram_wr && (store_cnt_q != '1)) ? store_cnt_q + 32'd1 : store_cnt_q;
    err_d          = (err_q & ~err_clr) | new_err;
    err_addr_d     = (new_err && !err_q) ? Mem_WrAddr : err_addr_q;
    tohost_valid_d = tohost_wr;
    tohost_data_d  = tohost_wr ? Mem_WrData : tohost_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q        <= '0;
      store_cnt_q    <= '0;
      err_q          <= 1'b0;
      err_addr_q     <= '0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else begin
      cycle_q        <= cycle_d;
      store_cnt_q    <= store_cnt_d;
      err_q          <= err_d;
      err_addr_q     <= err_addr_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
    end
  end

  assign misalign_err = err_q;
  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;

endmodule
